// File: rtl/axi_sram_slave.sv
// AXI3 slave fronting a single-port word RAM: one read and one write burst in flight,
// with the read fetch taking priority over the write commit on the shared RAM port.
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
) (
  input  logic                i_aclk,
  input  logic                i_areset,
  input  logic [ID_WIDTH-1:0] i_arid,
  input  logic [31:0]         i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic [1:0]          i_arburst,
  input  logic [1:0]          i_arlock,
  input  logic [3:0]          i_arcache,
  input  logic [2:0]          i_arprot,
  input  logic                i_arvalid,
  output logic                o_arready,
  output logic [ID_WIDTH-1:0] o_rid,
  output logic [31:0]         o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rlast,
  output logic                o_rvalid,
  input  logic                i_rready,
  input  logic [ID_WIDTH-1:0] i_awid,
  input  logic [31:0]         i_awaddr,
  input  logic [7:0]          i_awlen,
  input  logic [2:0]          i_awsize,
  input  logic [1:0]          i_awburst,
  input  logic [1:0]          i_awlock,
  input  logic [3:0]          i_awcache,
  input  logic [2:0]          i_awprot,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [ID_WIDTH-1:0] i_wid,
  input  logic [31:0]         i_wdata,
  input  logic [3:0]          i_wstrb,
  input  logic                i_wlast,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [ID_WIDTH-1:0] o_bid,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready
);

  // state   | meaning
  // R_IDLE  | waiting for AR
  // R_FETCH | RAM read of current beat (owns RAM port)
  // R_DATA  | beat presented on R, waiting for rready
  // W_IDLE  | waiting for AW
  // W_DATA  | accepting W beats
  // W_RESP  | B response presented, waiting for bready

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  function automatic logic [1:0] clamp_size(input logic [2:0] s);
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  logic [31:0] r_mem [DEPTH];

  rstate_t             r_rstate, w_rnext;
  logic [ID_WIDTH-1:0] r_rid;
  logic [31:0]         r_raddr;
  logic [3:0]          r_rlen, r_rcnt;
  logic [1:0]          r_rsize;
  logic                r_rfixed, r_rdecerr;
  logic [31:0]         r_rdata;

  wstate_t             r_wstate, w_wnext;
  logic [ID_WIDTH-1:0] r_wid;
  logic [31:0]         r_waddr;
  logic [3:0]          r_wlen, r_wcnt;
  logic [1:0]          r_wsize;
  logic                r_wfixed, r_wdecerr, r_wslverr;

  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs;
  logic w_rlast_beat, w_wlast_beat;

  assign w_rlast_beat = (r_rcnt == r_rlen);
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_ar_hs      = i_arvalid & o_arready;
  assign w_r_hs       = o_rvalid & i_rready;
  assign w_aw_hs      = i_awvalid & o_awready;
  assign w_w_hs       = i_wvalid & o_wready;

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rnext;
      r_wstate <= w_wnext;
    end
  end

  always_comb begin
    w_rnext   = r_rstate;
    o_arready = 1'b0;
    o_rvalid  = 1'b0;
    o_rlast   = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        o_arready = !i_areset;
        if (w_ar_hs) w_rnext = R_FETCH;
      end
      R_FETCH: w_rnext = R_DATA;
      R_DATA: begin
        o_rvalid = !i_areset;
        o_rlast  = !i_areset && w_rlast_beat;
        if (i_rready) w_rnext = w_rlast_beat ? R_IDLE : R_FETCH;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    w_wnext   = r_wstate;
    o_awready = 1'b0;
    o_wready  = 1'b0;
    o_bvalid  = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        o_awready = !i_areset;
        if (w_aw_hs) w_wnext = W_DATA;
      end
      W_DATA: begin
        // yield the RAM port to a read fetch
        o_wready = !i_areset && (r_rstate != R_FETCH);
        if (w_w_hs && w_wlast_beat) w_wnext = W_RESP;
      end
      W_RESP: begin
        o_bvalid = !i_areset;
        if (i_bready) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_rid     <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rsize   <= '0;
      r_rfixed  <= 1'b0;
      r_rdecerr <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rid     <= i_arid;
        r_raddr   <= i_araddr;
        r_rlen    <= i_arlen[3:0];
        r_rcnt    <= '0;
        r_rsize   <= clamp_size(i_arsize);
        r_rfixed  <= (i_arburst == 2'b00);
        r_rdecerr <= |i_araddr[31:ADDR_WIDTH];
      end
      if (r_rstate == R_FETCH)
        r_rdata <= r_rdecerr ? 32'd0 : r_mem[r_raddr[ADDR_WIDTH-1:2]];
      if (w_r_hs && !w_rlast_beat) begin
        r_rcnt <= r_rcnt + 4'd1;
        if (!r_rfixed) r_raddr <= r_raddr + (32'd1 << r_rsize);
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_wid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wsize   <= '0;
      r_wfixed  <= 1'b0;
      r_wdecerr <= 1'b0;
      r_wslverr <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_wid     <= i_awid;
        r_waddr   <= i_awaddr;
        r_wlen    <= i_awlen[3:0];
        r_wcnt    <= '0;
        r_wsize   <= clamp_size(i_awsize);
        r_wfixed  <= (i_awburst == 2'b00);
        r_wdecerr <= |i_awaddr[31:ADDR_WIDTH];
        r_wslverr <= 1'b0;
      end
      if (w_w_hs) begin
        if (i_wlast != w_wlast_beat) r_wslverr <= 1'b1;
        r_wcnt <= r_wcnt + 4'd1;
        if (!r_wfixed) r_waddr <= r_waddr + (32'd1 << r_wsize);
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (w_w_hs && !r_wdecerr) begin
      for (int b = 0; b < 4; b++)
        if (i_wstrb[b]) r_mem[r_waddr[ADDR_WIDTH-1:2]][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rid   = r_rid;
  assign o_rdata = r_rdata;
  assign o_rresp = r_rdecerr ? 2'b11 : 2'b00;
  assign o_bid   = r_wid;
  assign o_bresp = r_wdecerr ? 2'b11 : (r_wslverr ? 2'b10 : 2'b00);

  logic w_unused;
  assign w_unused = ^{i_arlen[7:4], i_awlen[7:4], i_arlock, i_awlock, i_arcache, i_awcache,
                      i_arprot, i_awprot, i_wid, r_raddr[31:ADDR_WIDTH], r_raddr[1:0],
                      r_waddr[31:ADDR_WIDTH], r_waddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: write/read, strobes, bursts, port sharing,
// decode/slave errors and reset in the middle of a read burst.
module tb_axi_sram_slave;

  localparam int LIM = 100;

  logic        aclk, areset;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_sram_slave #(.ADDR_WIDTH(16), .ID_WIDTH(4)) dut (
    .i_aclk(aclk), .i_areset(areset),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .i_arlock(arlock), .i_arcache(arcache), .i_arprot(arprot), .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
    .i_awlock(awlock), .i_awcache(awcache), .i_awprot(awprot), .i_awvalid(awvalid), .o_awready(awready),
    .i_wid(wid), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rexp [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // read-fetch cycles predicted from observed handshakes; wready must be low in each
  logic fetch_exp = 1'b0;
  bit   mon_en = 1'b0;
  int   n_fetch = 0, n_viol = 0;
  always @(posedge aclk)
    fetch_exp <= !areset && ((arvalid && arready) || (rvalid && rready && !rlast));
  always @(negedge aclk)
    if (mon_en && fetch_exp) begin
      n_fetch++;
      if (wready) n_viol++;
    end

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                             input bit early_last, input logic [1:0] exp_resp);
    int t;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = {4'd0, len}; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    t = 0;
    while (!awready && t < LIM) begin @(negedge aclk); t++; end
    check("aw_wait", 32'(t < LIM), 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wvalid = 1'b1;
      wlast = early_last ? (i == 0) : (i == int'(len));
      t = 0;
      while (!wready && t < LIM) begin @(negedge aclk); t++; end
      check("w_wait", 32'(t < LIM), 32'd1);
      @(posedge aclk);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (!bvalid && t < LIM) begin @(negedge aclk); t++; end
    check("b_wait", 32'(t < LIM), 32'd1);
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                            input bit fixed, input bit stall, input logic [1:0] exp_resp);
    int t;
    logic [31:0] held;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = {4'd0, len}; arsize = 3'd2;
    arburst = fixed ? 2'b00 : 2'b01; arvalid = 1'b1;
    t = 0;
    while (!arready && t < LIM) begin @(negedge aclk); t++; end
    check("ar_wait", 32'(t < LIM), 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid_lat1", 32'(rvalid), 32'd0);
    @(negedge aclk);
    check("rvalid_lat2", 32'(rvalid), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!rvalid && t < LIM) begin @(negedge aclk); t++; end
      check("r_wait", 32'(t < LIM), 32'd1);
      check($sformatf("rdata%0d", i), rdata, rexp[i]);
      check($sformatf("rresp%0d", i), 32'(rresp), 32'(exp_resp));
      check($sformatf("rid%0d", i), 32'(rid), 32'(id));
      check($sformatf("rlast%0d", i), 32'(rlast), 32'(i == int'(len)));
      if (stall) begin
        held = rdata;
        @(negedge aclk);
        check($sformatf("rhold%0d", i), rdata, held);
        check($sformatf("rhold_v%0d", i), 32'(rvalid), 32'd1);
      end
      rready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      rready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t, nv;
    areset = 1'b1;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid} = '0;
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
    {wid, wdata, wstrb, wlast, wvalid, rready, bready} = '0;
    repeat (3) @(negedge aclk);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ids", 32'({rid, bid}), 32'd0);
    check("rst_resps", 32'({rresp, bresp}), 32'd0);
    areset = 1'b0;

    // basic write then read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    write_burst(32'h10, 4'd1, 4'd0, 1'b0, 2'b00);
    rexp[0] = 32'hDEADBEEF;
    read_burst(32'h10, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);

    // byte strobes
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    write_burst(32'h10, 4'd2, 4'd0, 1'b0, 2'b00);
    rexp[0] = 32'hDE22BE44;
    read_burst(32'h10, 4'd3, 4'd0, 1'b0, 1'b0, 2'b00);

    // INCR burst with rready toggling, then a FIXED burst
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; rexp[i] = 32'(i + 1); end
    write_burst(32'h20, 4'd4, 4'd3, 1'b0, 2'b00);
    read_burst(32'h20, 4'd5, 4'd3, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) rexp[i] = 32'd2;
    read_burst(32'h24, 4'd6, 4'd2, 1'b1, 1'b0, 2'b00);

    // read and write sharing the RAM port
    for (int i = 0; i < 4; i++) rexp[i] = 32'(i + 1);
    wd[0] = 32'hA5A50001; wd[1] = 32'h5A5A0002; ws[0] = 4'hF; ws[1] = 4'hF;
    mon_en = 1'b1;
    fork
      read_burst(32'h20, 4'd7, 4'd3, 1'b0, 1'b0, 2'b00);
      write_burst(32'h40, 4'd8, 4'd1, 1'b0, 2'b00);
    join
    mon_en = 1'b0;
    check("fetch_cycles", 32'(n_fetch), 32'd4);
    check("wready_in_fetch", 32'(n_viol), 32'd0);
    rexp[0] = 32'hA5A50001; rexp[1] = 32'h5A5A0002;
    read_burst(32'h40, 4'd9, 4'd1, 1'b0, 1'b0, 2'b00);

    // decode errors
    rexp[0] = 32'd0;
    read_burst(32'h0001_0000, 4'd10, 4'd0, 1'b0, 1'b0, 2'b11);
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    write_burst(32'h0, 4'd11, 4'd0, 1'b0, 2'b00);
    wd[0] = 32'h12345678;
    write_burst(32'h0001_0000, 4'd12, 4'd0, 1'b0, 2'b11);
    rexp[0] = 32'hCAFEF00D;
    read_burst(32'h0, 4'd13, 4'd0, 1'b0, 1'b0, 2'b00);

    // early wlast -> SLVERR, data still committed
    wd[0] = 32'h77; wd[1] = 32'h88; ws[0] = 4'hF; ws[1] = 4'hF;
    write_burst(32'h50, 4'd14, 4'd1, 1'b1, 2'b10);
    rexp[0] = 32'h77; rexp[1] = 32'h88;
    read_burst(32'h50, 4'd15, 4'd1, 1'b0, 1'b0, 2'b00);

    // reset in the middle of a 4-beat read
    @(negedge aclk);
    arid = 4'd7; araddr = 32'h20; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (!rvalid && t < LIM) begin @(negedge aclk); t++; end
      check("rst_r_wait", 32'(t < LIM), 32'd1);
      check($sformatf("rst_rdata%0d", i), rdata, 32'(i + 1));
      if (i == 0) begin
        rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rready = 1'b0;
      end
    end
    areset = 1'b1;
    #1;
    check("mid_rst_arready", 32'(arready), 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("post_rst_rvalid", 32'(rvalid), 32'd0);
    check("post_rst_arready", 32'(arready), 32'd1);
    rready = 1'b1;
    nv = 0;
    repeat (8) begin @(negedge aclk); if (rvalid) nv++; end
    rready = 1'b0;
    check("post_rst_beats", 32'(nv), 32'd0);
    rexp[0] = 32'd1;
    read_burst(32'h20, 4'd2, 4'd0, 1'b0, 1'b0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 slave (responder) backing a single-port, word-organised on-chip RAM.
- Sits on the far side of the CPU's SRAM-to-AXI bridge and serves its AR/R and AW/W/B traffic in standalone simulation and FPGA bring-up.
- Runs one read and one write transaction concurrently, with INCR/FIXED bursts up to 16 beats.
- Read fetch and write commit are arbitrated onto the single RAM port.

Parameters:
- ADDR_WIDTH, 16: byte-address bits decoded. RAM depth is 2^(ADDR_WIDTH-2) 32-bit words.
- ID_WIDTH, 4: width of all AXI ID fields.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous reset, active-high.
- arid/awid  in  ID_WIDTH  transaction ID.
- araddr/awaddr  in  32  byte address.
- arlen/awlen  in  8  beats minus 1. Only bits [3:0] are used.
- arsize/awsize  in  3  bytes per beat = 1<<size. Values above 2 are treated as 2.
- arburst/awburst  in  2  00 = FIXED; any other value is treated as INCR.
- arlock/awlock (2), arcache/awcache (4), arprot/awprot (3)  in  accepted and ignored.
- arvalid/awvalid/wvalid  in  1  valid. arready/awready/wready  out  1  ready.
- rid  out  ID_WIDTH; rdata  out  32; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1.
- wid  in  ID_WIDTH  ignored; wdata  in  32; wstrb  in  4; wlast  in  1.
- bid  out  ID_WIDTH; bresp  out  2; bvalid  out  1; bready  in  1.

Behaviour:
- Reset: areset is sampled on aclk only; both FSMs go to IDLE.
  - Reset values: arready, awready, wready, rvalid, bvalid, rlast = 0; rid, rdata, rresp, bid, bresp = 0.
  - RAM contents are not cleared.
  - A transaction in flight when reset is asserted is dropped; no R or B beat is produced for it.
- Decode error: address bits [31:ADDR_WIDTH] != 0, latched from the AR/AW address.
  - Read: every beat returns rresp=11, rdata=0, with no RAM access.
  - Write: strobes are suppressed and bresp=11.
- Read FSM, states R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: arready=1. On the arvalid&arready handshake, latch id, addr, len, size, burst and decode-error; clear the beat counter; go to R_FETCH.
  - R_FETCH (1 cycle): RAM read at addr[ADDR_WIDTH-1:2]; go to R_DATA. The registered data appears in R_DATA.
  - R_DATA: rvalid=1. rdata/rid/rresp/rlast are held stable until rready. rlast=1 only when beat count == len.
    - On rready, last beat: go to R_IDLE.
    - On rready, not last beat: count+1; addr += 1<<size for INCR, unchanged for FIXED; go to R_FETCH.
  - Timing: rvalid rises 2 cycles after the AR handshake. Throughput is 1 beat per 2 cycles with rready held high.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1, wready=0 (W arriving before AW waits). On the AW handshake, latch id, addr, len, size, burst and decode-error; go to W_DATA.
  - W_DATA: wready=1 except in any cycle where the read FSM is in R_FETCH (read owns the RAM port that cycle).
    - Each W handshake writes the bytes with wstrb set into the current word. Address and count then advance as for reads.
    - On the beat where count == len, go to W_RESP.
    - If wlast disagrees with count == len on any beat, the error is flagged sticky and bresp=10 (SLVERR). Completion is still governed by awlen.
  - W_RESP: bvalid=1, bid = latched awid, bresp = 00 / 10 / 11. On bready, go to W_IDLE.
- The read and write FSMs are independent. AR and AW may both be accepted in the same cycle.
- A write beat committed in cycle t is visible to any R_FETCH in cycle t+1 or later.
- Unaligned address low bits: RAM indexing ignores addr[1:0]. The address increment uses the full byte address.

Test Plan:
- Basic write then read: AW 0x10 id=1, W 0xDEADBEEF strb=1111 -> B id=1 bresp=00. Then AR 0x10 id=0 -> rvalid 2 cycles after the handshake, rdata=0xDEADBEEF, rid=0, rresp=00, rlast=1.
- Byte strobes: over 0xDEADBEEF at 0x10, write 0x11223344 strb=0101 -> a read of 0x10 returns 0xDE22BE44.
- INCR read burst: write 1, 2, 3, 4 to 0x20..0x2C, then AR 0x20 arlen=3 size=2 with rready toggling 1/0 -> beats 1, 2, 3, 4 in order. rdata is stable while rready=0, and rlast is set only on beat 4.
- Port conflict: a 4-beat read burst in flight while a 2-beat write to 0x40 is offered -> wready=0 in every R_FETCH cycle, with no lost or corrupted beats. Both bursts complete, and a readback of 0x40/0x44 matches.
- Errors, with ADDR_WIDTH=16:
  - AR 0x00010000 -> rresp=11, rdata=0.
  - AW/W to 0x00010000 -> bresp=11, and RAM is unchanged.
  - awlen=1 with wlast=1 on beat 0 -> bresp=10.
- Reset mid-burst: areset high for 1 cycle during beat 2 of an arlen=3 read -> next cycle rvalid=0 and no further beats. arready=1 on the cycle after areset falls.
